// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the multi-channel pulse stretcher.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GUARD  = 2'd2
    } ps_state_e;

    // Width of the per-channel tick counter: wide enough to hold the larger
    // of the hold and guard lengths.
    function automatic int cnt_width(input int hold, input int guard);
        int m;
        m = (hold > guard) ? hold : guard;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulse_stretch_n.sv
// One stretcher channel: rising-edge detect, IDLE/ACTIVE/GUARD FSM,
// tick counter and a single pending-event flag for events seen in GUARD.
//
// state  | meaning
// IDLE   | output low, waiting for a rising edge on trigger
// ACTIVE | output high, counting hold ticks (optionally retriggerable)
// GUARD  | output low but busy, enforcing the minimum gap; remembers one event
module pulse_stretch_n
    import pulse_stretch_pkg::*;
#(
    parameter int HOLD_TICKS  = 4,
    parameter int GUARD_TICKS = 2,
    parameter int RETRIGGER   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic trigger,
    output logic result,
    output logic busy
);

    localparam int CW = cnt_width(HOLD_TICKS, GUARD_TICKS);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] GUARD_LAST = (GUARD_TICKS > 0) ? CW'(GUARD_TICKS - 1) : '0;

    ps_state_e     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          pending, pending_nxt;
    logic          prev;
    logic          evt;

    assign evt = trigger & ~prev;

    // Next-state, counter and pending-flag logic.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                if (evt) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = '0;
                end
            end
            ACTIVE: begin
                // A retrigger outranks a final tick landing on the same clock.
                if (evt && (RETRIGGER != 0)) begin
                    cnt_nxt = '0;
                end else if (tick) begin
                    if (cnt == HOLD_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = (GUARD_TICKS == 0) ? IDLE : GUARD;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            GUARD: begin
                if (tick && (cnt == GUARD_LAST)) begin
                    cnt_nxt     = '0;
                    pending_nxt = 1'b0;
                    state_nxt   = (pending || evt) ? ACTIVE : IDLE;
                end else begin
                    if (tick) cnt_nxt = cnt + 1'b1;
                    if (evt) pending_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                pending_nxt = 1'b0;
            end
        endcase
    end

    // State, counter, edge register and registered output decodes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            prev    <= 1'b0;
            result  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
            prev    <= trigger;
            result  <= (state_nxt == ACTIVE);
            busy    <= (state_nxt != IDLE);
        end
    end

endmodule

// File: rtl/pulse_stretch_multi.sv
// N-channel pulse stretcher: shared tick prescaler plus one independent
// stretcher channel per trigger bit.
module pulse_stretch_multi
    import pulse_stretch_pkg::*;
#(
    parameter int num_bits    = 8,
    parameter int PRESCALE_W  = 8,
    parameter int HOLD_TICKS  = 4,
    parameter int GUARD_TICKS = 2,
    parameter int RETRIGGER   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [num_bits-1:0] trigger,
    output logic [num_bits-1:0] result,
    output logic [num_bits-1:0] busy
);

    logic [PRESCALE_W-1:0] presc;
    logic                  tick;

    assign tick = &presc;

    // Free-running prescaler; tick marks the all-ones count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) presc <= '0;
        else        presc <= presc + 1'b1;
    end

    for (genvar i = 0; i < num_bits; i++) begin : g_ch
        pulse_stretch_n #(
            .HOLD_TICKS (HOLD_TICKS),
            .GUARD_TICKS(GUARD_TICKS),
            .RETRIGGER  (RETRIGGER)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .trigger(trigger[i]),
            .result (result[i]),
            .busy   (busy[i])
        );
    end

endmodule

// File: tb/tb_pulse_stretch_multi.sv
// Bench for pulse_stretch_multi: two instances (retrigger on / off) share
// stimulus; expected waveforms are queued per clock and compared after each edge.
module tb_pulse_stretch_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] trigger = 8'h00;
    logic [7:0] result_rt, busy_rt, result_nr, busy_nr;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [7:0] res_rt;
        logic [7:0] busy_rt;
        logic [7:0] res_nr;
        logic [7:0] busy_nr;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pulse_stretch_multi #(
        .num_bits(8), .PRESCALE_W(2), .HOLD_TICKS(3), .GUARD_TICKS(2), .RETRIGGER(1)
    ) u_dut_rt (
        .clk(clk), .reset(reset), .trigger(trigger), .result(result_rt), .busy(busy_rt)
    );

    pulse_stretch_multi #(
        .num_bits(8), .PRESCALE_W(2), .HOLD_TICKS(3), .GUARD_TICKS(2), .RETRIGGER(0)
    ) u_dut_nr (
        .clk(clk), .reset(reset), .trigger(trigger), .result(result_nr), .busy(busy_nr)
    );

    function automatic logic in_rng(int c, int a, int b);
        return (c >= a) && (c <= b);
    endfunction

    // Trigger level applied before clock c of each run.
    function automatic logic [7:0] trig_at(int run, int c);
        logic [7:0] v;
        v = 8'h00;
        case (run)
            0: begin
                v[0] = (c >= 1);
                v[2] = (c == 1) || (c >= 9);
                v[3] = (c == 1) || (c >= 14);
                v[4] = (c == 1) || (c >= 11);
            end
            1: v = (c >= 1) ? 8'hFF : 8'h00;
            2: v[0] = (c >= 1);
            default: v[0] = 1'b1;
        endcase
        return v;
    endfunction

    // Expected result after clock c (ticks at clocks 3, 7, 11, ...).
    function automatic logic [7:0] exp_res(int run, bit rt, int c);
        logic [7:0] v;
        v = 8'h00;
        case (run)
            0: begin
                v[0] = in_rng(c, 1, 10);
                v[2] = rt ? in_rng(c, 1, 18) : in_rng(c, 1, 10);
                v[3] = in_rng(c, 1, 10) || in_rng(c, 19, 30);
                v[4] = rt ? in_rng(c, 1, 22) : in_rng(c, 1, 10);
            end
            1: v = in_rng(c, 1, 10) ? 8'hFF : 8'h00;
            2: v[0] = in_rng(c, 1, 10);
            default: v[0] = in_rng(c, 0, 10);
        endcase
        return v;
    endfunction

    function automatic logic [7:0] exp_busy(int run, bit rt, int c);
        logic [7:0] v;
        v = 8'h00;
        case (run)
            0: begin
                v[0] = in_rng(c, 1, 18);
                v[2] = rt ? in_rng(c, 1, 26) : in_rng(c, 1, 18);
                v[3] = in_rng(c, 1, 38);
                v[4] = rt ? in_rng(c, 1, 30) : in_rng(c, 1, 18);
            end
            1: v = in_rng(c, 1, 18) ? 8'hFF : 8'h00;
            2: v[0] = in_rng(c, 1, 18);
            default: v[0] = in_rng(c, 0, 18);
        endcase
        return v;
    endfunction

    task automatic check8(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    // Hold reset for a few clocks (checking the reset state), release between edges.
    task automatic do_reset(input logic [7:0] trig_hold);
        reset = 1'b0;
        trigger = trig_hold;
        repeat (3) @(posedge clk);
        #1;
        check8("rst_res_rt", -1, result_rt, 8'h00);
        check8("rst_busy_rt", -1, busy_rt, 8'h00);
        check8("rst_res_nr", -1, result_nr, 8'h00);
        check8("rst_busy_nr", -1, busy_nr, 8'h00);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_cycles(input int run, input int ncyc);
        exp_t e;
        exp_t got;
        for (int c = 0; c < ncyc; c++) begin
            trigger   = trig_at(run, c);
            e.cyc     = c;
            e.res_rt  = exp_res(run, 1'b1, c);
            e.busy_rt = exp_busy(run, 1'b1, c);
            e.res_nr  = exp_res(run, 1'b0, c);
            e.busy_nr = exp_busy(run, 1'b0, c);
            sb.push_back(e);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            check8($sformatf("r%0d_res_rt", run), got.cyc, result_rt, got.res_rt);
            check8($sformatf("r%0d_busy_rt", run), got.cyc, busy_rt, got.busy_rt);
            check8($sformatf("r%0d_res_nr", run), got.cyc, result_nr, got.res_nr);
            check8($sformatf("r%0d_busy_nr", run), got.cyc, busy_nr, got.busy_nr);
        end
    endtask

    initial begin
        // Single event, retrigger, event in guard, event on final tick.
        do_reset(8'h00);
        run_cycles(0, 44);

        // All channels at once, then held high: one pulse each.
        do_reset(8'h00);
        run_cycles(1, 40);

        // Asynchronous reset in the middle of a pulse.
        do_reset(8'h00);
        run_cycles(2, 6);
        #2;
        reset = 1'b0;
        #1;
        check8("async_res_rt", 5, result_rt, 8'h00);
        check8("async_busy_rt", 5, busy_rt, 8'h00);
        check8("async_res_nr", 5, result_nr, 8'h00);
        check8("async_busy_nr", 5, busy_nr, 8'h00);

        // Trigger held high across release: exactly one fresh pulse.
        do_reset(8'h01);
        run_cycles(3, 41);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
